mcycle_ctrl: RTL and testbench
==============================

# mcycle_ctrl

Parametrised multicycle control FSM for the MIPS core: sequences each instruction through Fetch, Decode, Execute, Memory and Writeback and drives one-hot stage enables plus the writeback-source select. It adds three things to the basic five-state controller: a request/acknowledge handshake on instruction and data memory, a configurable multi-cycle execute for MULT, and illegal-opcode detection. It sits beside the datapath in the multicycle top level and is the only source of stage enables.

## Interface
- MUL_LAT, 4: execute cycles for MULT; legal range 1..255.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- instr  in  32  current instruction from IR; the datapath holds it stable from Decode until the return to Fetch
- imem_ack  in  1  instruction memory has data this cycle
- dmem_ack  in  1  data memory access completes this cycle
- fetch_en, decode_en, execute_en, memory_en, writeback_en  out  1 each  one-hot stage enables
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- ir_we  out  1  latch IR and PC+4
- wb_sel  out  1  writeback source: 0 = execute result, 1 = memory data
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retire  out  1  one-cycle pulse when an instruction completes
- cycle_cnt, instret_cnt  out  CNT_W each  performance counters

## Operation
- States: S_F, S_D, S_E, S_M, S_W. The stage enables are a Moore decode of the current state, so exactly one enable is high in every cycle.
- op = instr[31:26]; func = instr[5:0].
- S_F:
  - imem_req=1.
  - imem_ack: ir_we=1 in that same cycle, then go to S_D.
  - Otherwise stay in S_F.
- S_D:
  - F6_J: go to S_F.
  - R-type with func==F6_NOP: go to S_F.
  - F6_BEQ, F6_SW, F6_LW, F6_ADDI, or any other R-type: go to S_E.
  - Any other opcode: pulse illegal and go to S_F.
- S_E:
  - F6_BEQ: go to S_F.
  - R-type (not MULT) or F6_ADDI: go to S_W and set wb_sel=0.
  - F6_SW or F6_LW: go to S_M.
  - R-type with func==F6_MULT: on entry to S_E, mul_cnt loads MUL_LAT-1. The FSM stays in S_E and decrements mul_cnt while mul_cnt≠0. When it reaches 0, go to S_W and set wb_sel=0.
- S_M:
  - dmem_req=1; dmem_we=1 if op==F6_SW.
  - No dmem_ack: stay in S_M.
  - dmem_ack with F6_SW: go to S_F.
  - dmem_ack with F6_LW: go to S_W and set wb_sel=1.
- S_W: go to S_F.
- wb_sel is registered. It changes only on an E→W or M→W transition and otherwise holds.
- retire pulses on every transition into S_F from S_D, S_E, S_M or S_W, except the D→F transition that pulses illegal.
- An unreachable state encoding recovers to S_F on the next clock.

## Timing
- Reset values:
  - state S_F, so fetch_en=1 and imem_req=1.
  - All other enables 0; dmem_req, dmem_we, ir_we, illegal, retire 0.
  - wb_sel 0; mul_cnt 0; counters 0.
- Reset asserted mid-instruction: the FSM returns to S_F at once, any outstanding request is dropped, and the datapath discards partial results.
- Minimum cycles per instruction with zero-wait memory:
  - J, NOP: 2.
  - BEQ: 3.
  - R-type, ADDI, SW: 4.
  - LW: 5.
  - MULT: 3+MUL_LAT.
- Every memory wait cycle adds one cycle.
- Requests are level signals held until ack. An ack while the matching request is low is ignored.
- imem_ack is honoured in the first S_F cycle, so back-to-back instructions need no idle cycle.

## Configuration
- MCYC_PERF_CNT_EN defined: cycle_cnt increments every clock after reset, and instret_cnt increments on each retire pulse. Both wrap modulo 2^CNT_W.
- MCYC_PERF_CNT_EN undefined: no counter registers are built, and cycle_cnt and instret_cnt are tied to 0.

## Structure
- Package pipes holds:
  - state enum mcyc_state_t;
  - state_enable_t, extended with wb_sel;
  - opcode/func constants F6_J, F6_BEQ, F6_SW, F6_LW, F6_ADDI, F6_R_TYPE, F6_NOP, plus the new F6_MULT (6'h18).
- mcyc_decode sub-module: combinational classifier from op/func to class {JUMP, NOP, BRANCH, ALU, MUL, LOAD, STORE, ILLEGAL}. The FSM consumes only the class.

## Test plan
- Reset, then LW with imem_ack and dmem_ack held high → states F,D,E,M,W; wb_sel=1 in W; retire after 5 cycles.
- MULT with MUL_LAT=4 → exactly 4 cycles of execute_en; W entered on cycle 7; wb_sel=0.
- SW with dmem_ack delayed 3 cycles → memory_en, dmem_req and dmem_we held 4 cycles; direct return to F; no writeback_en.
- Opcode 6'h3F in Decode → one illegal pulse, back to fetch_en, no retire, instret_cnt unchanged.
- Reset asserted during S_M of LW → next cycle fetch_en=1, dmem_req=0, wb_sel=0.
- With MCYC_PERF_CNT_EN: 10 J instructions with zero-wait fetch → instret_cnt=10, cycle_cnt=20. Without the macro, both counters read 0.

Source files
------------

// File: rtl/pipes.sv
// Shared types and constants for the multicycle MIPS controller:
// FSM states, stage-enable bundle, instruction classes and opcode/func codes.
package pipes;

  typedef enum logic [2:0] {
    S_F = 3'd0,
    S_D = 3'd1,
    S_E = 3'd2,
    S_M = 3'd3,
    S_W = 3'd4
  } mcyc_state_t;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic execute;
    logic memory;
    logic writeback;
    logic wb_sel;
  } state_enable_t;

  typedef enum logic [2:0] {
    C_JUMP,
    C_NOP,
    C_BRANCH,
    C_ALU,
    C_MUL,
    C_LOAD,
    C_STORE,
    C_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] F6_R_TYPE = 6'h00;
  localparam logic [5:0] F6_J      = 6'h02;
  localparam logic [5:0] F6_BEQ    = 6'h04;
  localparam logic [5:0] F6_ADDI   = 6'h08;
  localparam logic [5:0] F6_LW     = 6'h23;
  localparam logic [5:0] F6_SW     = 6'h2B;
  localparam logic [5:0] F6_NOP    = 6'h00;
  localparam logic [5:0] F6_MULT   = 6'h18;

  // Moore decode of the stage enables; wb_sel is filled in from its register.
  function automatic state_enable_t stage_enables(input mcyc_state_t s);
    state_enable_t e;
    e           = '0;
    e.fetch     = (s == S_F);
    e.decode    = (s == S_D);
    e.execute   = (s == S_E);
    e.memory    = (s == S_M);
    e.writeback = (s == S_W);
    return e;
  endfunction

endpackage

// File: rtl/mcycle_ctrl_decode.sv
// Combinational instruction classifier: maps op/func onto the small set of
// classes the control FSM sequences on.
module mcyc_decode
  import pipes::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_t cls
);

  always_comb begin
    cls = C_ILLEGAL;
    case (op)
      F6_J:      cls = C_JUMP;
      F6_BEQ:    cls = C_BRANCH;
      F6_ADDI:   cls = C_ALU;
      F6_LW:     cls = C_LOAD;
      F6_SW:     cls = C_STORE;
      F6_R_TYPE: begin
        if (func == F6_NOP)       cls = C_NOP;
        else if (func == F6_MULT) cls = C_MUL;
        else                      cls = C_ALU;
      end
      default:   cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS control FSM (F/D/E/M/W) with memory handshakes, multi-cycle
// MULT execute and illegal-opcode detection. Counters need MCYC_PERF_CNT_EN.
module mcycle_ctrl
  import pipes::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             wb_sel,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);

  mcyc_state_t   state_reg, state_next;
  instr_class_t  cls;
  logic [7:0]    mul_cnt_reg;
  logic          wb_sel_reg;
  state_enable_t en;
  logic          unused_instr;

  assign unused_instr = ^instr[25:6];

  mcyc_decode u_decode (
    .op   (instr[31:26]),
    .func (instr[5:0]),
    .cls  (cls)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_F;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_F;
    case (state_reg)
      S_F: state_next = imem_ack ? S_D : S_F;
      S_D: begin
        case (cls)
          C_BRANCH, C_ALU, C_MUL, C_LOAD, C_STORE: state_next = S_E;
          default:                                 state_next = S_F;
        endcase
      end
      S_E: begin
        case (cls)
          C_ALU:            state_next = S_W;
          C_MUL:            state_next = (mul_cnt_reg != 8'd0) ? S_E : S_W;
          C_LOAD, C_STORE:  state_next = S_M;
          default:          state_next = S_F;
        endcase
      end
      S_M: begin
        if (!dmem_ack)           state_next = S_M;
        else if (cls == C_LOAD)  state_next = S_W;
        else                     state_next = S_F;
      end
      S_W:     state_next = S_F;
      default: state_next = S_F;
    endcase
  end

  // Output logic
  always_comb begin
    en        = stage_enables(state_reg);
    en.wb_sel = wb_sel_reg;
    imem_req  = (state_reg == S_F);
    ir_we     = (state_reg == S_F) && imem_ack;
    dmem_req  = (state_reg == S_M);
    dmem_we   = (state_reg == S_M) && (cls == C_STORE);
    illegal   = (state_reg == S_D) && (cls == C_ILLEGAL);
    retire    = (state_reg inside {S_D, S_E, S_M, S_W}) && (state_next == S_F) && !illegal;
  end

  assign fetch_en     = en.fetch;
  assign decode_en    = en.decode;
  assign execute_en   = en.execute;
  assign memory_en    = en.memory;
  assign writeback_en = en.writeback;
  assign wb_sel       = en.wb_sel;

  // mul_cnt is loaded on D->E so the first execute cycle already counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt_reg <= 8'd0;
    end else if (state_reg == S_D && state_next == S_E) begin
      mul_cnt_reg <= (cls == C_MUL) ? MUL_LOAD : 8'd0;
    end else if (state_reg == S_E && mul_cnt_reg != 8'd0) begin
      mul_cnt_reg <= mul_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_sel_reg <= 1'b0;
    end else if (state_next == S_W) begin
      if (state_reg == S_E)      wb_sel_reg <= 1'b0;
      else if (state_reg == S_M) wb_sel_reg <= 1'b1;
    end
  end

`ifdef MCYC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (retire) instret_cnt_reg <= instret_cnt_reg + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed, table-driven bench for mcycle_ctrl plus hand-written sequences for
// reset-in-memory and the performance counters.
module tb_mcycle_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic [31:0]      instr;
  logic             imem_ack;
  logic             dmem_ack;
  logic             fetch_en, decode_en, execute_en, memory_en, writeback_en;
  logic             imem_req, dmem_req, dmem_we, ir_we, wb_sel, illegal, retire;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  mcycle_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .fetch_en     (fetch_en),
    .decode_en    (decode_en),
    .execute_en   (execute_en),
    .memory_en    (memory_en),
    .writeback_en (writeback_en),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_we        (ir_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .retire       (retire),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: F D E M W | imem_req dmem_req dmem_we ir_we | wb_sel illegal retire
  logic [11:0] obs;
  assign obs = {fetch_en, decode_en, execute_en, memory_en, writeback_en,
                imem_req, dmem_req, dmem_we, ir_we, wb_sel, illegal, retire};

  typedef struct {
    logic [31:0] instr;
    logic        ia;
    logic        da;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_MULT = 32'h0000_0018;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;
  localparam logic [31:0] I_J    = 32'h0800_0000;
  localparam logic [31:0] I_BEQ  = 32'h1000_0000;
  localparam logic [31:0] I_ADDI = 32'h2000_0000;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ADD  = 32'h0000_0020;

  task automatic add(input logic [31:0] i, input logic ia, input logic da, input logic [11:0] e);
    vec_t v;
    v.instr = i; v.ia = ia; v.da = da; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] i, input logic ia, input logic da);
    instr = i; imem_ack = ia; dmem_ack = da;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    // LW, all acks high
    add(I_LW,   1, 1, 12'b10000_1001_000);
    add(I_LW,   1, 1, 12'b01000_0000_000);
    add(I_LW,   1, 1, 12'b00100_0000_000);
    add(I_LW,   1, 1, 12'b00010_0100_000);
    add(I_LW,   1, 1, 12'b00001_0000_101);
    // MULT, four execute cycles, wb_sel still 1 from LW until W
    add(I_MULT, 1, 0, 12'b10000_1001_100);
    add(I_MULT, 1, 0, 12'b01000_0000_100);
    for (int k = 0; k < 4; k++) add(I_MULT, 1, 0, 12'b00100_0000_100);
    add(I_MULT, 1, 0, 12'b00001_0000_001);
    // SW with one fetch wait and three data waits
    add(I_SW,   0, 0, 12'b10000_1000_000);
    add(I_SW,   1, 0, 12'b10000_1001_000);
    add(I_SW,   1, 0, 12'b01000_0000_000);
    add(I_SW,   1, 1, 12'b00100_0000_000);
    for (int k = 0; k < 3; k++) add(I_SW, 1, 0, 12'b00010_0110_000);
    add(I_SW,   1, 1, 12'b00010_0110_001);
    // illegal opcode
    add(I_ILL,  1, 0, 12'b10000_1001_000);
    add(I_ILL,  1, 0, 12'b01000_0000_010);
    // J, BEQ, ADDI, NOP, ADD
    add(I_J,    1, 1, 12'b10000_1001_000);
    add(I_J,    1, 1, 12'b01000_0000_001);
    add(I_BEQ,  1, 0, 12'b10000_1001_000);
    add(I_BEQ,  1, 0, 12'b01000_0000_000);
    add(I_BEQ,  1, 0, 12'b00100_0000_001);
    add(I_ADDI, 1, 0, 12'b10000_1001_000);
    add(I_ADDI, 1, 0, 12'b01000_0000_000);
    add(I_ADDI, 1, 0, 12'b00100_0000_000);
    add(I_ADDI, 1, 0, 12'b00001_0000_001);
    add(I_NOP,  1, 0, 12'b10000_1001_000);
    add(I_NOP,  1, 0, 12'b01000_0000_001);
    add(I_ADD,  1, 0, 12'b10000_1001_000);
    add(I_ADD,  1, 0, 12'b01000_0000_000);
    add(I_ADD,  1, 0, 12'b00100_0000_000);
    add(I_ADD,  1, 0, 12'b00001_0000_001);

    // Reset state
    reset = 1'b1;
    drive(I_NOP, 0, 0);
    @(negedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'(12'b10000_1000_000));
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instret_cnt", instret_cnt, 32'd0);
    reset = 1'b0;

    // Table vectors, one per clock
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].instr, vecs[k].ia, vecs[k].da);
      check($sformatf("vec%0d", k), 32'(obs), 32'(vecs[k].exp));
      @(negedge clk);
    end

    // Full LW to set wb_sel, then a second LW held in S_M and reset there
    for (int k = 0; k < 5; k++) begin
      drive(I_LW, 1, 1);
      @(negedge clk);
    end
    drive(I_LW, 1, 0); @(negedge clk);
    drive(I_LW, 1, 0); @(negedge clk);
    drive(I_LW, 1, 0); @(negedge clk);
    drive(I_LW, 0, 0);
    check("lw_wait_in_mem", 32'({memory_en, dmem_req, wb_sel}), 32'(3'b111));
    reset = 1'b1;
    #1;
    check("reset_in_mem", 32'({fetch_en, memory_en, dmem_req, wb_sel}), 32'(4'b1000));
    @(negedge clk);
    check("reset_in_mem_next", 32'({fetch_en, dmem_req, wb_sel}), 32'(3'b100));
    reset = 1'b0;

    // Ten zero-wait jumps, then an illegal opcode
    for (int k = 0; k < 10; k++) begin
      drive(I_J, 1, 0); @(negedge clk);
      drive(I_J, 1, 0); @(negedge clk);
    end
    #1;
`ifdef MCYC_PERF_CNT_EN
    check("j10_instret_cnt", instret_cnt, 32'd10);
    check("j10_cycle_cnt", cycle_cnt, 32'd20);
`else
    check("j10_instret_cnt", instret_cnt, 32'd0);
    check("j10_cycle_cnt", cycle_cnt, 32'd0);
`endif
    drive(I_ILL, 1, 0); @(negedge clk);
    drive(I_ILL, 1, 0);
    check("ill_pulse", 32'({decode_en, illegal, retire}), 32'(3'b110));
    @(negedge clk);
    #1;
    check("ill_back_to_fetch", 32'({fetch_en, illegal}), 32'(2'b10));
`ifdef MCYC_PERF_CNT_EN
    check("ill_instret_cnt", instret_cnt, 32'd10);
    check("ill_cycle_cnt", cycle_cnt, 32'd22);
`else
    check("ill_instret_cnt", instret_cnt, 32'd0);
    check("ill_cycle_cnt", cycle_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
